count_enable_gen: RTL and testbench
===================================

COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

Interface
REQ-001 SHALL provide parameter CLK_SELECT_BIT_WIDTH, default 3, width of clock_select; only value 3 is supported.
REQ-002 SHALL have clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have TMCI0  input  1  external count clock 0, asynchronous to clk.
REQ-005 SHALL have TMCI1  input  1  external count clock 1, asynchronous to clk.
REQ-006 SHALL have clock_select  input  CLK_SELECT_BIT_WIDTH  count source select.
REQ-007 SHALL have edge_select  input  2  external edge mode: 00 rising, 01 falling, 1x both edges.
REQ-008 SHALL have enable  input  1  count gate; 0 suppresses count_en.
REQ-009 SHALL have count_en  output  1  single-cycle count-enable pulse for the counter.
REQ-010 SHALL have switch_busy  output  1  high while a source switch is in progress.
REQ-011 SHALL have active_select  output  3  source currently in effect.

Function
REQ-012 SHALL replace derived clocks with clk-domain enable pulses; no output is used as a clock.
REQ-013 SHALL keep a 13-bit free-running prescaler, incremented every cycle, wrapping 8191->0, never stopped by enable or switching.
REQ-014 SHALL decode active_select: 000 /2, 001 /8, 010 /32, 011 /64, 100 /1024, 101 /8192, 110 TMCI0, 111 TMCI1.
REQ-015 Internal source /N SHALL raise the raw tick in the cycle where prescaler low log2(N) bits are all ones (one tick per N cycles).
REQ-016 Each TMCI input SHALL pass a 2-flop synchronizer plus one history flop; edge = synchronized value vs history.
REQ-017 External raw tick SHALL assert per edge_select on the selected TMCI; latency input edge -> count_en is 3 clk cycles.
REQ-018 count_en SHALL be registered: count_en = raw tick AND enable AND state==RUN, from the previous cycle's values.
REQ-019 count_en SHALL never be high in two consecutive cycles except for source /2.
REQ-020 FSM states: RUN, FLUSH1, FLUSH2.
REQ-021 RUN -> FLUSH1 when clock_select != active_select; active_select loads clock_select in that same cycle.
REQ-022 FLUSH1 -> FLUSH2 -> RUN unconditionally, unless REQ-023 applies.
REQ-023 A clock_select change during FLUSH1/FLUSH2 SHALL reload active_select and return to FLUSH1.
REQ-024 During FLUSH1/FLUSH2, history flops SHALL load the synchronized values so no stale edge is counted after the switch.
REQ-025 switch_busy SHALL be high exactly in FLUSH1/FLUSH2; no count_en SHALL be generated for ticks arising in those states.
REQ-026 edge_select changes SHALL take effect next cycle without FLUSH.
REQ-027 enable deassertion SHALL suppress count_en from the next cycle; ticks while disabled are dropped, not queued.

Reset
REQ-028 On rst_n=0 at posedge: prescaler=0, synchronizer and history flops=0, state=RUN, active_select=clock_select, count_en=0, switch_busy=0.
REQ-029 Reset SHALL abort a switch in progress; first count_en is no earlier than 2 cycles after rst_n rises.

Verification
REQ-030 select=001, enable=1, 64 cycles after reset -> count_en pulses 8 times, spaced exactly 8 cycles, switch_busy=0.
REQ-031 select=110, edge_select=00, TMCI0 toggles 5 full periods -> 5 pulses, each 3 cycles after a rising edge; edge_select=10 -> 10 pulses.
REQ-032 select 000->101 mid-run -> switch_busy high 2 cycles, active_select=101, no pulse in those cycles, next pulse at prescaler low 13 bits all ones.
REQ-033 select 110->111 while TMCI1 held high -> no spurious pulse after FLUSH; first pulse follows next qualifying TMCI1 edge.
REQ-034 enable=0 for 20 cycles on /8 -> no pulses; re-enable -> pulses resume aligned to prescaler phase, none extra.
REQ-035 rst_n=0 asserted during FLUSH1 -> next cycle state=RUN, switch_busy=0, count_en=0, prescaler=0.

Source files
------------

// File: rtl/count_enable_gen_if.sv
// Control/status bundle for count_enable_gen: count sources and select in, count-enable
// pulse and switch status out.
interface count_enable_gen_if #(
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3
);
  logic                            TMCI0;
  logic                            TMCI1;
  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select;
  logic [1:0]                      edge_select;
  logic                            enable;
  logic                            count_en;
  logic                            switch_busy;
  logic [2:0]                      active_select;

  modport master (
    output TMCI0, TMCI1, clock_select, edge_select, enable,
    input  count_en, switch_busy, active_select
  );

  modport slave (
    input  TMCI0, TMCI1, clock_select, edge_select, enable,
    output count_en, switch_busy, active_select
  );
endinterface

// File: rtl/count_enable_gen.sv
// Count-enable generator: turns prescaled clk or synchronized TMCI edges into single-cycle
// clk-domain enable pulses, with a two-cycle flush whenever the count source is switched.
module count_enable_gen #(
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3
) (
  input logic               clk,
  input logic               rst_n,
  count_enable_gen_if.slave ctrl
);

  typedef enum logic [1:0] {StRun, StFlush1, StFlush2} state_e;

  state_e      state_q, state_d;
  logic [2:0]  act_q, act_d;
  logic [12:0] presc_q;
  // Bit 0 tracks TMCI0, bit 1 tracks TMCI1.
  logic [1:0]  sync1_q, sync2_q, hist_q;
  logic        count_en_q, count_en_d;

  logic [2:0]  sel_req;
  logic        switch_req;
  logic        int_tick, ext_tick, raw_tick;
  logic        ext_sync, ext_hist, ext_rise, ext_fall;

  assign sel_req    = ctrl.clock_select;
  assign switch_req = (sel_req != act_q);

  // State register; reset adopts the requested source directly, aborting any switch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      act_q   <= sel_req;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  // Next state: any select change (re)starts the flush from FLUSH1.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    if (switch_req) begin
      state_d = StFlush1;
      act_d   = sel_req;
    end else begin
      unique case (state_q)
        StFlush1: state_d = StFlush2;
        StFlush2: state_d = StRun;
        default:  state_d = StRun;
      endcase
    end
  end

  // History always follows the synchronized value, so after a flush it has caught up and
  // no stale edge from the newly selected TMCI can be seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
      count_en_q <= 1'b0;
    end else begin
      presc_q    <= presc_q + 13'd1;
      sync1_q    <= {ctrl.TMCI1, ctrl.TMCI0};
      sync2_q    <= sync1_q;
      hist_q     <= sync2_q;
      count_en_q <= count_en_d;
    end
  end

  always_comb begin
    int_tick = 1'b0;
    unique case (act_q)
      3'd0:    int_tick = presc_q[0];
      3'd1:    int_tick = &presc_q[2:0];
      3'd2:    int_tick = &presc_q[4:0];
      3'd3:    int_tick = &presc_q[5:0];
      3'd4:    int_tick = &presc_q[9:0];
      3'd5:    int_tick = &presc_q[12:0];
      default: int_tick = 1'b0;
    endcase
  end

  assign ext_sync = act_q[0] ? sync2_q[1] : sync2_q[0];
  assign ext_hist = act_q[0] ? hist_q[1]  : hist_q[0];
  assign ext_rise = ext_sync & ~ext_hist;
  assign ext_fall = ~ext_sync & ext_hist;

  always_comb begin
    ext_tick = ext_rise;
    if (ctrl.edge_select[1]) begin
      ext_tick = ext_rise | ext_fall;
    end else if (ctrl.edge_select[0]) begin
      ext_tick = ext_fall;
    end
  end

  assign raw_tick = (act_q[2] & act_q[1]) ? ext_tick : int_tick;

  // A pending switch also blocks the pulse: that tick belongs to the source being left.
  assign count_en_d = raw_tick & ctrl.enable & (state_q == StRun) & ~switch_req;

  always_comb begin
    ctrl.count_en      = count_en_q;
    ctrl.switch_busy   = (state_q != StRun);
    ctrl.active_select = act_q;
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Randomized plus directed bench for count_enable_gen; a per-cycle behavioural model feeds a
// scoreboard queue that an independent monitor drains and compares.
module tb_count_enable_gen;

  typedef struct packed {
    logic       en;
    logic       busy;
    logic [2:0] act;
  } exp_t;

  logic clk;
  logic rst_n;

  count_enable_gen_if #(.CLK_SELECT_BIT_WIDTH(3)) ctrl ();

  count_enable_gen #(.CLK_SELECT_BIT_WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pulse_cnt = 0;
  exp_t expq[$];

  // Reference model state: prescaler as a cycle count, flush as cycles remaining, and the
  // raw TMCI values sampled at the last three clock edges (index 0 newest).
  int unsigned m_presc;
  int unsigned m_left;
  logic [2:0]  m_act;
  logic [2:0]  m_smp0, m_smp1;
  int unsigned div_tab [6] = '{2, 8, 32, 64, 1024, 8192};

  initial begin
    exp_t        e;
    logic        tick, now_v, old_v;
    int unsigned n;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_presc = 0;
        m_left  = 0;
        m_act   = ctrl.clock_select;
        m_smp0  = '0;
        m_smp1  = '0;
        e.en    = 1'b0;
      end else begin
        if (m_act < 3'd6) begin
          n    = div_tab[m_act];
          tick = ((m_presc % n) == n - 1);
        end else begin
          // Edge seen by the counter: samples taken two and three edges ago.
          now_v = (m_act == 3'd6) ? m_smp0[1] : m_smp1[1];
          old_v = (m_act == 3'd6) ? m_smp0[2] : m_smp1[2];
          if (ctrl.edge_select[1])      tick = (now_v != old_v);
          else if (ctrl.edge_select[0]) tick = (!now_v && old_v);
          else                          tick = (now_v && !old_v);
        end
        e.en = tick && ctrl.enable && (m_left == 0) && (ctrl.clock_select == m_act);
        if (ctrl.clock_select != m_act) begin
          m_act  = ctrl.clock_select;
          m_left = 2;
        end else if (m_left > 0) begin
          m_left = m_left - 1;
        end
        m_presc = (m_presc + 1) % 8192;
        m_smp0  = {m_smp0[1:0], ctrl.TMCI0};
        m_smp1  = {m_smp1[1:0], ctrl.TMCI1};
      end
      e.busy = (m_left != 0);
      e.act  = m_act;
      expq.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_checks++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty t=%0t: got no expectation, required one per cycle",
                 $time);
      end else begin
        e = expq.pop_front();
        if (ctrl.count_en !== e.en || ctrl.switch_busy !== e.busy ||
            ctrl.active_select !== e.act) begin
          n_fail++;
          $display("FAIL cycle_out t=%0t: got en=%b busy=%b act=%0d, required en=%b busy=%b act=%0d",
                   $time, ctrl.count_en, ctrl.switch_busy, ctrl.active_select,
                   e.en, e.busy, e.act);
        end
      end
      if (ctrl.count_en === 1'b1) pulse_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic tmci0_periods(input int periods);
    for (int i = 0; i < periods; i++) begin
      ctrl.TMCI0 = 1'b1;
      step(4);
      ctrl.TMCI0 = 1'b0;
      step(4);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    ctrl.clock_select  = 3'd1;
    ctrl.edge_select   = 2'b00;
    ctrl.enable        = 1'b1;
    ctrl.TMCI0         = 1'b0;
    ctrl.TMCI1         = 1'b0;
    step(3);
    check("reset_busy", int'(ctrl.switch_busy), 0);
    check("reset_count_en", int'(ctrl.count_en), 0);

    // /8 for 64 cycles after reset.
    rst_n     = 1'b1;
    pulse_cnt = 0;
    step(64);
    check("div8_pulses", pulse_cnt, 8);

    // TMCI0 rising edges, then both edges.
    ctrl.clock_select = 3'd6;
    step(4);
    pulse_cnt = 0;
    tmci0_periods(5);
    step(4);
    check("tmci0_rise_pulses", pulse_cnt, 5);
    ctrl.edge_select = 2'b10;
    pulse_cnt        = 0;
    tmci0_periods(5);
    step(4);
    check("tmci0_both_pulses", pulse_cnt, 10);

    // /2 to /8192 mid-run.
    ctrl.edge_select  = 2'b00;
    ctrl.clock_select = 3'd0;
    step(20);
    ctrl.clock_select = 3'd5;
    step(1);
    check("switch_busy_f1", int'(ctrl.switch_busy), 1);
    step(2);
    check("switch_busy_done", int'(ctrl.switch_busy), 0);
    check("active_select_5", int'(ctrl.active_select), 5);
    pulse_cnt = 0;
    step(8192);
    check("div8192_pulses", pulse_cnt, 1);

    // TMCI0 to TMCI1 while TMCI1 is already high.
    ctrl.clock_select = 3'd6;
    ctrl.TMCI1        = 1'b1;
    step(6);
    ctrl.clock_select = 3'd7;
    pulse_cnt         = 0;
    step(10);
    check("tmci1_no_spurious", pulse_cnt, 0);
    ctrl.TMCI1 = 1'b0;
    step(4);
    ctrl.TMCI1 = 1'b1;
    step(5);
    check("tmci1_first_edge", pulse_cnt, 1);

    // Enable gating on /8.
    ctrl.clock_select = 3'd1;
    step(10);
    ctrl.enable = 1'b0;
    pulse_cnt   = 0;
    step(20);
    check("disabled_pulses", pulse_cnt, 0);
    ctrl.enable = 1'b1;
    pulse_cnt   = 0;
    step(64);
    check("reenabled_pulses", pulse_cnt, 8);

    // Reset while in FLUSH1.
    ctrl.clock_select = 3'd3;
    step(1);
    check("flush1_entered", int'(ctrl.switch_busy), 1);
    rst_n = 1'b0;
    step(1);
    check("reset_aborts_busy", int'(ctrl.switch_busy), 0);
    check("reset_aborts_en", int'(ctrl.count_en), 0);
    rst_n = 1'b1;

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0)  ctrl.clock_select = 3'($urandom_range(7));
      if ($urandom_range(49) == 0)  ctrl.edge_select  = 2'($urandom_range(3));
      if ($urandom_range(29) == 0)  ctrl.enable       = ~ctrl.enable;
      if ($urandom_range(2) == 0)   ctrl.TMCI0        = ~ctrl.TMCI0;
      if ($urandom_range(2) == 0)   ctrl.TMCI1        = ~ctrl.TMCI1;
      rst_n = ($urandom_range(499) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
